// File: rtl/clk_mon.sv
// Clock monitor: measures period and high time of an asynchronous clock in
// reference-clock cycles, checks it against a window, and flags loss of activity.
module clk_mon #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 en_i,
  input  logic                 mon_clk_i,
  input  logic [CNT_WIDTH-1:0] exp_min_i,
  input  logic [CNT_WIDTH-1:0] exp_max_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 meas_valid_o,
  output logic                 too_fast_o,
  output logic                 too_slow_o,
  output logic                 lost_o,
  output logic                 locked_o
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOST} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_WIDTH-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   high_q, high_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   too_fast_q, too_fast_d;
  logic                   too_slow_q, too_slow_d;
  logic                   lost_q, lost_d;
  logic                   locked_q, locked_d;
  logic                   mon_s, rise, tmo_hit;
  logic                   set_fast, set_slow, set_lost;

  assign mon_s   = sync_q[SYNC_STAGES-1];
  assign rise    = mon_s & ~hist_q;
  // tmo_cnt counts cycles since the last rise, or since entering ARM
  assign tmo_hit = (timeout_i != '0) && (tmo_cnt_q >= timeout_i);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], mon_clk_i};
    hist_d       = mon_s;
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    run_cnt_d    = run_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    set_fast     = 1'b0;
    set_slow     = 1'b0;
    set_lost     = 1'b0;

    if (!en_i) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      tmo_cnt_d = '0;
      run_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          tmo_cnt_d = CNT_ONE;
          run_cnt_d = '0;
        end
        ARM: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            tmo_cnt_d = CNT_ONE;
          end else if (tmo_hit) begin
            state_d   = LOST;
            set_lost  = 1'b1;
            run_cnt_d = '0;
          end else begin
            tmo_cnt_d = sat_inc(tmo_cnt_q);
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = per_cnt_q;
            high_d       = hi_cnt_q;
            meas_valid_d = 1'b1;
            per_cnt_d    = CNT_ONE;
            hi_cnt_d     = CNT_ONE;
            tmo_cnt_d    = CNT_ONE;
            if (per_cnt_q < exp_min_i) begin
              set_fast  = 1'b1;
              run_cnt_d = '0;
            end else if (per_cnt_q > exp_max_i) begin
              set_slow  = 1'b1;
              run_cnt_d = '0;
            end else if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else if (tmo_hit) begin
            state_d   = LOST;
            set_lost  = 1'b1;
            run_cnt_d = '0;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
            hi_cnt_d  = mon_s ? sat_inc(hi_cnt_q) : hi_cnt_q;
            tmo_cnt_d = sat_inc(tmo_cnt_q);
          end
        end
        LOST: begin
          run_cnt_d = '0;
          // the interrupted period is never published; start fresh
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            tmo_cnt_d = CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    too_fast_d = (too_fast_q & ~clr_i) | set_fast;
    too_slow_d = (too_slow_q & ~clr_i) | set_slow;
    lost_d     = (lost_q & ~clr_i) | set_lost;
    locked_d   = (run_cnt_d == RUN_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      hist_q       <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      tmo_cnt_q    <= '0;
      run_cnt_q    <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      too_fast_q   <= 1'b0;
      too_slow_q   <= 1'b0;
      lost_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hist_q       <= hist_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      run_cnt_q    <= run_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      too_fast_q   <= too_fast_d;
      too_slow_q   <= too_slow_d;
      lost_q       <= lost_d;
      locked_q     <= locked_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign meas_valid_o = meas_valid_q;
  assign too_fast_o   = too_fast_q;
  assign too_slow_o   = too_slow_q;
  assign lost_o       = lost_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: default-width instance plus an 8-bit instance for saturation.
module tb_clk_mon;

  logic        clk = 1'b0;
  logic        srst, en, mon, clr;
  logic [15:0] exp_min, exp_max, tmo;
  logic [15:0] period, high;
  logic        valid, fast, slow, lost, locked;
  logic [7:0]  period8, high8;
  logic        valid8, fast8, slow8, lost8, locked8;

  int n_tests = 0;
  int n_fail  = 0;

  bit   gen_on    = 1'b0;
  int   gen_per   = 8;
  int   gen_hi    = 4;
  int   phase     = 0;
  logic mon_force = 1'b0;

  always #5 clk = ~clk;

  clk_mon dut (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mon_clk_i(mon),
    .exp_min_i(exp_min), .exp_max_i(exp_max), .timeout_i(tmo), .clr_i(clr),
    .period_o(period), .high_o(high), .meas_valid_o(valid),
    .too_fast_o(fast), .too_slow_o(slow), .lost_o(lost), .locked_o(locked)
  );

  clk_mon #(.CNT_WIDTH(8)) dut8 (
    .clk_i(clk), .srst_i(srst), .en_i(en), .mon_clk_i(mon),
    .exp_min_i(exp_min[7:0]), .exp_max_i(exp_max[7:0]), .timeout_i(tmo[7:0]), .clr_i(clr),
    .period_o(period8), .high_o(high8), .meas_valid_o(valid8),
    .too_fast_o(fast8), .too_slow_o(slow8), .lost_o(lost8), .locked_o(locked8)
  );

  // monitored-clock generator, updated on the falling edge of clk
  initial begin
    mon = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        mon   = (phase < gen_hi);
        phase = (phase + 1 == gen_per) ? 0 : phase + 1;
      end else begin
        mon   = mon_force;
        phase = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input bit w8, input int max, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < max) begin
      @(negedge clk);
      waited++;
      if ((w8 ? valid8 : valid) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    gen_on = 1'b0; mon_force = 1'b0; en = 1'b0; clr = 1'b0;
    srst = 1'b1;
    cyc(3);
    srst = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    en = 1'b0; clr = 1'b0; mon_force = 1'b0; gen_on = 1'b0;
    exp_min = 16'd6; exp_max = 16'd10; tmo = 16'd0;
    srst = 1'b1;
    cyc(2);
    n_tests++;
    if (period !== 16'd0 || high !== 16'd0) begin
      n_fail++; $display("FAIL reset_meas: period=%0d high=%0d expected 0 0", period, high);
    end
    n_tests++;
    if ({valid, fast, slow, lost, locked} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {valid, fast, slow, lost, locked});
    end
    n_tests++;
    if ({period8, high8} !== 16'd0 || {valid8, fast8, slow8, lost8, locked8} !== 5'b0) begin
      n_fail++; $display("FAIL reset_dut8: period=%0d high=%0d flags=%b expected all 0",
                         period8, high8, {valid8, fast8, slow8, lost8, locked8});
    end
    srst = 1'b0;
    cyc(1);
  endtask

  task automatic test_lock();
    bit ok; int w;
    do_reset();
    exp_min = 16'd6; exp_max = 16'd10; tmo = 16'd0;
    gen_per = 8; gen_hi = 4; gen_on = 1'b1; en = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      wait_valid(1'b0, 40, ok, w);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL lock_pulse%0d: no meas_valid within %0d cycles", p, w);
      end
      n_tests++;
      if (period !== 16'd8 || high !== 16'd4) begin
        n_fail++; $display("FAIL lock_meas%0d: period=%0d high=%0d expected 8 4", p, period, high);
      end
      n_tests++;
      if (locked !== (p >= 4) || {fast, slow, lost} !== 3'b000) begin
        n_fail++; $display("FAIL lock_state%0d: locked=%b flags=%b expected %b 000",
                           p, locked, {fast, slow, lost}, (p >= 4));
      end
    end
  endtask

  task automatic test_lost();
    bit ok; int w;
    tmo = 16'd20;
    wait_valid(1'b0, 40, ok, w);
    gen_on = 1'b0; mon_force = 1'b0;
    n_tests++;
    if (!ok || locked !== 1'b1) begin
      n_fail++; $display("FAIL lost_prelock: ok=%b locked=%b expected 1 1", ok, locked);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 19) begin
        n_tests++;
        if (lost !== 1'b0 || locked !== 1'b1) begin
          n_fail++; $display("FAIL lost_early: lost=%b locked=%b expected 0 1 at 19 cycles", lost, locked);
        end
      end
      if (k == 20) begin
        n_tests++;
        if (lost !== 1'b1 || locked !== 1'b0) begin
          n_fail++; $display("FAIL lost_at20: lost=%b locked=%b expected 1 0", lost, locked);
        end
      end
    end
    cyc(10);
    gen_on = 1'b1;
    wait_valid(1'b0, 60, ok, w);
    n_tests++;
    if (!ok || period !== 16'd8 || high !== 16'd4) begin
      n_fail++; $display("FAIL lost_restart: ok=%b period=%0d high=%0d expected 1 8 4", ok, period, high);
    end
    n_tests++;
    if (locked !== 1'b0 || lost !== 1'b1) begin
      n_fail++; $display("FAIL lost_restart_flags: locked=%b lost=%b expected 0 1", locked, lost);
    end
  endtask

  task automatic test_enable();
    bit ok; int w; bit seen;
    for (int p = 0; p < 3; p++) wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || locked !== 1'b1) begin
      n_fail++; $display("FAIL enable_relock: ok=%b locked=%b expected 1 1", ok, locked);
    end
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i > 0 && valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen || locked !== 1'b0 || period !== 16'd8 || high !== 16'd4) begin
      n_fail++; $display("FAIL enable_off: pulse=%b locked=%b period=%0d high=%0d expected 0 0 8 4",
                         seen, locked, period, high);
    end
  endtask

  task automatic test_too_fast();
    bit ok; int w;
    do_reset();
    exp_min = 16'd10; exp_max = 16'd12; tmo = 16'd0;
    gen_on = 1'b1; en = 1'b1;
    wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || fast !== 1'b1 || slow !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL fast_first: ok=%b fast=%b slow=%b locked=%b expected 1 1 0 0",
                         ok, fast, slow, locked);
    end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n_tests++;
    if (fast !== 1'b0) begin
      n_fail++; $display("FAIL fast_clr: fast=%b expected 0", fast);
    end
    wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || fast !== 1'b1 || period !== 16'd8) begin
      n_fail++; $display("FAIL fast_reassert: ok=%b fast=%b period=%0d expected 1 1 8", ok, fast, period);
    end
    for (int p = 0; p < 4; p++) wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL fast_nolock: locked=%b expected 0", locked);
    end
  endtask

  task automatic test_clr_coincident();
    bit ok; int w;
    do_reset();
    exp_min = 16'd2; exp_max = 16'd5; tmo = 16'd0;
    gen_on = 1'b1; en = 1'b1;
    wait_valid(1'b0, 40, ok, w);
    wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || slow !== 1'b1 || fast !== 1'b0) begin
      n_fail++; $display("FAIL slow_flag: ok=%b slow=%b fast=%b expected 1 1 0", ok, slow, fast);
    end
    cyc(7);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n_tests++;
    if (valid !== 1'b1 || slow !== 1'b1) begin
      n_fail++; $display("FAIL clr_coincident: valid=%b slow=%b expected 1 1", valid, slow);
    end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n_tests++;
    if (slow !== 1'b0) begin
      n_fail++; $display("FAIL slow_clr: slow=%b expected 0", slow);
    end
  endtask

  task automatic test_saturate();
    bit ok; int w;
    do_reset();
    exp_min = 16'd6; exp_max = 16'd10; tmo = 16'd0;
    gen_on = 1'b1; en = 1'b1;
    wait_valid(1'b1, 40, ok, w);
    gen_on = 1'b0; mon_force = 1'b0;
    cyc(300);
    gen_on = 1'b1;
    wait_valid(1'b1, 40, ok, w);
    n_tests++;
    if (!ok || period8 !== 8'd255 || slow8 !== 1'b1) begin
      n_fail++; $display("FAIL sat_dut8: ok=%b period=%0d slow=%b expected 1 255 1", ok, period8, slow8);
    end
    n_tests++;
    if (period <= 16'd255 || slow !== 1'b1) begin
      n_fail++; $display("FAIL sat_dut16: period=%0d slow=%b expected >255 1", period, slow);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int w;
    do_reset();
    exp_min = 16'd6; exp_max = 16'd10; tmo = 16'd0;
    gen_on = 1'b1; en = 1'b1;
    for (int p = 0; p < 5; p++) wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || locked !== 1'b1) begin
      n_fail++; $display("FAIL mid_prelock: ok=%b locked=%b expected 1 1", ok, locked);
    end
    cyc(3);
    srst = 1'b1;
    cyc(1);
    srst = 1'b0;
    n_tests++;
    if (period !== 16'd0 || high !== 16'd0 || {valid, fast, slow, lost, locked} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset: period=%0d high=%0d flags=%b expected 0 0 00000",
                         period, high, {valid, fast, slow, lost, locked});
    end
    wait_valid(1'b0, 40, ok, w);
    n_tests++;
    if (!ok || w < 9 || period !== 16'd8 || high !== 16'd4) begin
      n_fail++; $display("FAIL mid_rearm: ok=%b wait=%0d period=%0d high=%0d expected 1 >=9 8 4",
                         ok, w, period, high);
    end
  endtask

  initial begin
    srst = 1'b1; en = 1'b0; clr = 1'b0;
    exp_min = '0; exp_max = '0; tmo = '0;
    test_reset();
    test_lock();
    test_lost();
    test_enable();
    test_too_fast();
    test_clr_coincident();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of all cycle counters and period/threshold fields.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on mon_clk_i (minimum 2).
REQ-003 Parameter LOCK_COUNT, default 4, consecutive in-window periods required to assert locked_o.
REQ-004 clk_i  input  1  reference clock; the only clock; all logic is on its rising edge.
REQ-005 srst_i  input  1  synchronous, active-high reset.
REQ-006 en_i  input  1  monitor enable; 0 holds the FSM in IDLE.
REQ-007 mon_clk_i  input  1  monitored clock (e.g. clk_div clk_o), asynchronous to clk_i, treated as data.
REQ-008 exp_min_i  input  CNT_WIDTH  minimum allowed period in clk_i cycles, inclusive.
REQ-009 exp_max_i  input  CNT_WIDTH  maximum allowed period in clk_i cycles, inclusive.
REQ-010 timeout_i  input  CNT_WIDTH  cycles without a rising edge before loss is declared; 0 disables.
REQ-011 clr_i  input  1  clears sticky fault flags.
REQ-012 period_o  output  CNT_WIDTH  last measured period in clk_i cycles.
REQ-013 high_o  output  CNT_WIDTH  last measured high time in clk_i cycles.
REQ-014 meas_valid_o  output  1  one-cycle pulse when period_o/high_o update.
REQ-015 too_fast_o  output  1  sticky: a period < exp_min_i was measured.
REQ-016 too_slow_o  output  1  sticky: a period > exp_max_i was measured.
REQ-017 lost_o  output  1  sticky: timeout expired without a rising edge.
REQ-018 locked_o  output  1  level: last LOCK_COUNT periods were all in window.

Function
REQ-019 mon_clk_i SHALL pass through SYNC_STAGES flops, then one history flop; rise/fall detect = synchronized value differs from history value.
REQ-020 FSM states SHALL be IDLE, ARM, MEASURE, LOST.
REQ-021 IDLE -> ARM when en_i=1; any state -> IDLE in the cycle after en_i=0.
REQ-022 ARM: period/high counters held at 0; first detected rise -> MEASURE with both counters loaded to 1.
REQ-023 MEASURE: period counter increments every cycle; high counter increments while synchronized level is 1 and stops at the detected fall.
REQ-024 On a detected rise in MEASURE: period_o <= period count, high_o <= high count, meas_valid_o=1 next cycle, counters reload to 1.
REQ-025 Counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-026 Window check on each measurement: period < exp_min_i sets too_fast_o; period > exp_max_i sets too_slow_o; else the in-window run counter increments (saturating at LOCK_COUNT).
REQ-027 locked_o=1 while run counter = LOCK_COUNT; any out-of-window measurement, loss, or exit from MEASURE clears run counter and locked_o in the same update.
REQ-028 Timeout: in ARM or MEASURE, when timeout_i != 0 and cycles since last rise (or since entering ARM) reach timeout_i, go to LOST, set lost_o, clear locked_o.
REQ-029 LOST: detected rise -> MEASURE with counters loaded to 1; no measurement published for the interrupted period.
REQ-030 clr_i clears too_fast_o, too_slow_o, lost_o; if a set condition occurs in the same cycle, set wins.
REQ-031 Leaving MEASURE (en_i=0 or loss) SHALL keep period_o/high_o at last published values.
REQ-032 Threshold inputs SHALL be sampled at the measurement cycle; exp_min_i > exp_max_i flags every period as out of window.

Reset
REQ-033 srst_i=1 SHALL force IDLE, all counters and synchronizer flops to 0, period_o=0, high_o=0, meas_valid_o=0, all flags=0, locked_o=0, on the next clk_i edge, regardless of state.
REQ-034 Reset mid-measurement SHALL discard the partial count; no meas_valid_o pulse is produced by reset.

Verification
REQ-035 en_i=1, mon_clk_i period 8 cycles (4 high), window 6..10 -> period_o=8, high_o=4 each rise, locked_o=1 after 4th valid pulse, no flags.
REQ-036 Window 10..12, period 8 -> too_fast_o=1 on first measurement, locked_o stays 0; clr_i pulse -> too_fast_o re-asserts on next measurement.
REQ-037 timeout_i=20, mon_clk_i stopped after lock -> lost_o=1, locked_o=0 exactly 20 cycles after last detected rise; restart -> MEASURE, first pulse reports the new full period.
REQ-038 timeout_i=0, mon_clk_i held low, CNT_WIDTH=8 -> count saturates at 255; next rise publishes period_o=255, too_slow_o=1.
REQ-039 srst_i asserted mid-period while locked -> all outputs 0 next cycle; after release, ARM waits a full period before the first measurement.
REQ-040 clr_i coincident with a too_slow measurement -> too_slow_o=1 after that cycle.
